// File: rtl/image_stream_tx.sv
// Frame source for the image filter: host-loaded frame buffer, streamed in raster order, then a
// processing handshake guarded by a watchdog. First pixel two edges after start; no backpressure.
module image_stream_tx #(
  parameter int WIDTH   = 410,
  parameter int DEPTH   = 361,
  parameter int ADDR_W  = 18,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              start,
  input  logic              finish,
  output logic [7:0]        image_input,
  output logic              enable,
  output logic              enable_process,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NPIX   = WIDTH * DEPTH;
  localparam int PIX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LINE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] NPIX_A    = ADDR_W'(NPIX);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(WIDTH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(DEPTH - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_GAP,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        img_q, img_d;
  logic              en_q, en_d;
  logic              ep_q, ep_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [7:0] mem_q [NPIX];
  logic [7:0] ram_q;
  logic       wr_en;
  logic       rd_en;

  // addr_q runs one pixel ahead of pix/line to cover the RAM read latency
  assign wr_en = (state_q == S_IDLE) && load_we && (load_addr < NPIX_A);
  assign rd_en = (state_q == S_PRIME) || ((state_q == S_STREAM) && (addr_q < NPIX_A));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[load_addr] <= load_data;
    end
    if (rd_en) begin
      ram_q <= mem_q[addr_q];
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    img_d   = img_q;
    en_d    = en_q;
    ep_d    = ep_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRIME;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          pix_d   = '0;
          line_d  = '0;
          addr_d  = '0;
          wd_d    = '0;
        end
      end
      S_PRIME: begin
        addr_d  = addr_q + 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        img_d = ram_q;
        en_d  = 1'b1;
        if (rd_en) begin
          addr_d = addr_q + 1'b1;
        end
        if (pix_q == PIX_LAST) begin
          pix_d = '0;
          if (line_q == LINE_LAST) begin
            state_d = S_GAP;
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      S_GAP: begin
        en_d    = 1'b0;
        ep_d    = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // finish only counts once enable_process has been visible for a cycle
        if (ep_q && finish) begin
          ep_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (wd_q == WD_LIMIT) begin
          ep_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          ep_d = 1'b1;
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        ep_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      img_q   <= '0;
      en_q    <= 1'b0;
      ep_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      img_q   <= img_d;
      en_q    <= en_d;
      ep_q    <= ep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign image_input    = img_q;
  assign enable         = en_q;
  assign enable_process = ep_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;

endmodule
